// File: rtl/nibble_serial_subtractor_if.sv
// Handshake/data bundle between the ALU sequencer and nibble_serial_subtractor.
//   start, a, b, b_in            : request and operands (sequencer -> subtractor)
//   busy, done                   : status (subtractor -> sequencer)
//   diff, b_out, zero, neg, ovf  : result and flags (subtractor -> sequencer)
// master = sequencer side, slave = subtractor side.
interface nibble_serial_subtractor_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             b_out;
  logic             zero;
  logic             neg;
  logic             ovf;

  modport master (
    output start, a, b, b_in,
    input  busy, done, diff, b_out, zero, neg, ovf
  );

  modport slave (
    input  start, a, b, b_in,
    output busy, done, diff, b_out, zero, neg, ovf
  );
endinterface

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - b_in (mod 2^WIDTH), one 4-bit slice
// per clock using a 4-bit carry-lookahead on (a, ~b) with a registered carry
// between slices.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : slave side of nibble_serial_subtractor_if
//          (start/a/b/b_in in; busy/done/diff/b_out/zero/neg/ovf out)
// Latency is N = WIDTH/4 clocks from the accepting edge; done pulses for the
// single DONE cycle and results hold until the next completion.
module nibble_serial_subtractor #(
  parameter int WIDTH = 16
) (
  input logic                     clk,
  input logic                     rst,
  nibble_serial_subtractor_if.slave bus
);
  localparam int N  = WIDTH / 4;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [KW-1:0]    k_reg;
  logic             c_reg;
  // Operands shift right by one nibble per slice, so the current slice is
  // always in bits [3:0]; the sign bits are kept aside for the overflow test.
  logic [WIDTH-1:0] a_sh_reg, b_sh_reg;
  logic             a_msb_reg, b_msb_reg;
  // Result nibbles shift in from the top; after N slices slice 0 sits at [3:0].
  logic [WIDTH-1:0] work_reg;
  logic [WIDTH-1:0] diff_reg;
  logic             b_out_reg, zero_reg, neg_reg, ovf_reg;

  logic [3:0]       a_nib, nb_nib, p, g, sum;
  logic [4:0]       c;
  logic [WIDTH-1:0] work_next;
  logic             accept, last_slice;

  assign accept     = ((state_reg == IDLE) || (state_reg == DONE)) && bus.start;
  assign last_slice = (k_reg == KW'(N - 1));

  // Slice arithmetic: a_k + ~b_k + c with full lookahead carries.
  assign a_nib  = a_sh_reg[3:0];
  assign nb_nib = ~b_sh_reg[3:0];
  assign p      = a_nib ^ nb_nib;
  assign g      = a_nib & nb_nib;
  assign c[0]   = c_reg;
  assign c[1]   = g[0] | (p[0] & c[0]);
  assign c[2]   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3]   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
  assign c[4]   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);
  assign sum    = p ^ c[3:0];

  assign work_next = (work_reg >> 4) | (WIDTH'(sum) << (WIDTH - 4));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last_slice) state_next = DONE;
      DONE:    state_next = bus.start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_reg     <= '0;
      c_reg     <= 1'b0;
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      a_msb_reg <= 1'b0;
      b_msb_reg <= 1'b0;
      work_reg  <= '0;
      diff_reg  <= '0;
      b_out_reg <= 1'b0;
      zero_reg  <= 1'b0;
      neg_reg   <= 1'b0;
      ovf_reg   <= 1'b0;
    end else if (accept) begin
      k_reg     <= '0;
      c_reg     <= ~bus.b_in;  // subtract as a + ~b + 1 - b_in
      a_sh_reg  <= bus.a;
      b_sh_reg  <= bus.b;
      a_msb_reg <= bus.a[WIDTH-1];
      b_msb_reg <= bus.b[WIDTH-1];
    end else if (state_reg == RUN) begin
      k_reg    <= k_reg + KW'(1);
      c_reg    <= c[4];
      a_sh_reg <= a_sh_reg >> 4;
      b_sh_reg <= b_sh_reg >> 4;
      work_reg <= work_next;
      if (last_slice) begin
        diff_reg  <= work_next;
        b_out_reg <= ~c[4];
        zero_reg  <= (work_next == '0);
        neg_reg   <= work_next[WIDTH-1];
        // Sign test uses a and b only; b_in does not enter it.
        ovf_reg   <= (a_msb_reg != b_msb_reg) && (work_next[WIDTH-1] != a_msb_reg);
      end
    end
  end

  assign bus.busy  = (state_reg == RUN);
  assign bus.done  = (state_reg == DONE);
  assign bus.diff  = diff_reg;
  assign bus.b_out = b_out_reg;
  assign bus.zero  = zero_reg;
  assign bus.neg   = neg_reg;
  assign bus.ovf   = ovf_reg;
endmodule

// File: tb/tb_nibble_serial_subtractor.sv
module tb_nibble_serial_subtractor;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  nibble_serial_subtractor_if #(.WIDTH(16)) bus ();

  nibble_serial_subtractor #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] flags();
    return {bus.b_out, bus.zero, bus.neg, bus.ovf};
  endfunction

  // One complete operation: accept, scramble operands mid-run, measure latency
  // and busy width, check result/flags, then check the done pulse ends.
  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic bi, input logic [15:0] ed, input logic [3:0] ef);
    int lat;
    int busy_cnt;
    @(negedge clk);
    bus.start = 1'b1; bus.a = av; bus.b = bv; bus.b_in = bi;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0; bus.a = 16'hDEAD; bus.b = 16'hBEEF; bus.b_in = ~bi;
    lat = 0; busy_cnt = 0;
    while (!bus.done && lat < 10) begin
      if (bus.busy) busy_cnt++;
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, lat, 4);
    chk({tag, " busy_cycles"}, busy_cnt, 4);
    chk({tag, " diff"}, bus.diff, ed);
    chk({tag, " flags(bo,z,n,o)"}, flags(), ef);
    chk({tag, " busy_at_done"}, bus.busy, 0);
    $display("op %s: %h - %h - %0d -> diff=%h flags=%b lat=%0d", tag, av, bv, bi, bus.diff, flags(), lat);
    @(negedge clk);
    chk({tag, " done_pulse_end"}, bus.done, 0);
    chk({tag, " diff_hold"}, bus.diff, ed);
  endtask

  initial begin
    int lat;
    int done_cnt;
    checks = 0; failures = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.b_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset busy", bus.busy, 0);
    chk("reset done", bus.done, 0);
    chk("reset diff", bus.diff, 0);
    chk("reset flags", flags(), 0);
    rst = 1'b0;

    run_op("1234-0034",   16'h1234, 16'h0034, 1'b0, 16'h1200, 4'b0000);
    run_op("0000-0001",   16'h0000, 16'h0001, 1'b0, 16'hFFFF, 4'b1010);
    run_op("8000-0001",   16'h8000, 16'h0001, 1'b0, 16'h7FFF, 4'b0001);
    run_op("7FFF-FFFF",   16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 4'b1011);
    run_op("5555-5555-0", 16'h5555, 16'h5555, 1'b0, 16'h0000, 4'b0100);
    run_op("5555-5555-1", 16'h5555, 16'h5555, 1'b1, 16'hFFFF, 4'b1010);

    // start pulsed during slice 1 with different operands must be ignored
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'h1000; bus.b = 16'h0001; bus.b_in = 1'b0;
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk); @(negedge clk);
    bus.start = 1'b1; bus.a = 16'hFFFF; bus.b = 16'h0000; bus.b_in = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0;
    lat = 2;
    while (!bus.done && lat < 10) begin
      @(posedge clk); @(negedge clk);
      lat++;
    end
    chk("ignore latency", lat, 4);
    chk("ignore diff", bus.diff, 16'h0FFF);
    chk("ignore flags", flags(), 4'b0000);
    $display("op ignore-start: 1000 - 0001 -> diff=%h lat=%0d", bus.diff, lat);
    @(negedge clk);
    chk("ignore not_queued busy", bus.busy, 0);
    chk("ignore not_queued done", bus.done, 0);

    // start held high through DONE: back-to-back accept
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'h0010; bus.b = 16'h0001; bus.b_in = 1'b0;
    @(posedge clk); @(negedge clk);
    bus.a = 16'h0003; bus.b = 16'h0005; bus.b_in = 1'b0;
    lat = 0;
    while (!bus.done && lat < 10) begin
      @(posedge clk); @(negedge clk);
      lat++;
    end
    chk("b2b first latency", lat, 4);
    chk("b2b first diff", bus.diff, 16'h000F);
    chk("b2b first flags", flags(), 4'b0000);
    $display("op b2b-first: 0010 - 0001 -> diff=%h lat=%0d", bus.diff, lat);
    @(posedge clk); @(negedge clk);
    chk("b2b reaccept busy", bus.busy, 1);
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 10) begin
      @(posedge clk); @(negedge clk);
      lat++;
    end
    chk("b2b second latency", lat, 4);
    chk("b2b second diff", bus.diff, 16'hFFFE);
    chk("b2b second flags", flags(), 4'b1010);
    $display("op b2b-second: 0003 - 0005 -> diff=%h lat=%0d", bus.diff, lat);

    // reset while k=2 aborts the operation
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'hAAAA; bus.b = 16'h1111; bus.b_in = 1'b0;
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0;
    repeat (2) begin
      @(posedge clk); @(negedge clk);
    end
    rst = 1'b1;
    #1;
    chk("abort busy", bus.busy, 0);
    chk("abort done", bus.done, 0);
    chk("abort diff", bus.diff, 0);
    chk("abort flags", flags(), 0);
    $display("op abort: reset during slice 2");
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    repeat (6) begin
      @(posedge clk); @(negedge clk);
      if (bus.done) done_cnt++;
    end
    chk("abort no_done", done_cnt, 0);

    run_op("00FF-000F", 16'h00FF, 16'h000F, 1'b0, 16'h00F0, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/nibble_serial_subtractor.md
# nibble_serial_subtractor

Multi-cycle WIDTH-bit subtractor computing diff = a − b − b_in, one 4-bit slice per clock. It is the inverse-direction companion to the 4-bit carry-lookahead adder slice. Each cycle evaluates one nibble with lookahead propagate/generate terms on (a, ~b) and a registered carry between slices. It sits in the ALU datapath as the low-area subtract/compare unit, driven by a start/done handshake from the sequencer.

## Interface
- WIDTH, 16, operand width in bits; must be a multiple of 4; N = WIDTH/4 slices.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request; sampled only when state is IDLE or DONE.
- a  in  WIDTH  minuend; captured on the accepting edge.
- b  in  WIDTH  subtrahend; captured on the accepting edge.
- b_in  in  1  borrow-in; captured on the accepting edge.
- busy  out  1  high while state is RUN.
- done  out  1  one-cycle pulse; result outputs are valid from this cycle onward.
- diff  out  WIDTH  result a − b − b_in, modulo 2^WIDTH.
- b_out  out  1  borrow-out; 1 when the unsigned a < b + b_in.
- zero  out  1  diff == 0.
- neg  out  1  diff[WIDTH-1].
- ovf  out  1  two's-complement overflow.

## Operation
- Arithmetic per slice k:
  - Compute a_k + ~b_k + c, with p = a_k ^ ~b_k and g = a_k & ~b_k.
  - Slice carries use full 4-bit lookahead equations.
  - Initial c = ~b_in. Slice carry-out is registered into c for slice k+1.
- States:
  - IDLE: reset state.
  - RUN: slice counter k runs 0..N-1.
  - DONE: lasts one cycle.
- Transitions:
  - IDLE → RUN on start=1. Latches a, b, b_in; sets c = ~b_in and k = 0.
  - RUN: each edge computes slice k into the working register and advances k.
  - RUN → DONE on the edge that processes slice N-1. On that edge, load diff, b_out, zero, neg and ovf from the completed working value.
  - DONE → IDLE if start=0.
  - DONE → RUN if start=1. This back-to-back request is accepted and new operands are latched.
- Flag definitions:
  - b_out = ~(final carry).
  - zero = (diff == 0).
  - neg = diff MSB.
  - ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]). ovf ignores b_in's contribution to the sign test.
- Result outputs (diff and flags) hold the last completed result until the next completion. They never show partial slices.
- start while busy=1 is ignored. It is neither queued nor allowed to corrupt the latched operands.
- Changes on a, b or b_in after the accepting edge have no effect on the current operation.

## Timing
- Reset values: state IDLE, busy 0, done 0, diff 0, b_out 0, zero 0, neg 0, ovf 0. Internal k, c and operand registers are cleared.
- Reset asserted mid-RUN aborts immediately: no done pulse, and outputs return to reset values. The first start after reset release behaves normally.
- Edge E0 accepts start, so busy=1 after E0.
- Edges E1..EN process slices 0..N-1.
- After EN: busy=0, done=1, results valid. Latency is N clocks from the accepting edge; 4 for WIDTH=16.
- Throughput: one result per N+1 cycles with an idle DONE cycle between operations. With start held high, it is one result per N+1 edges (DONE→RUN counts as the next accept edge).
- done is high for exactly one cycle per completed operation.

## Test plan
- 0x1234 − 0x0034, b_in=0 → diff 0x1200; b_out 0, zero 0, neg 0, ovf 0. done is high exactly 4 clocks after the start edge; busy is high for 4 cycles.
- 0x0000 − 0x0001, b_in=0 → diff 0xFFFF, b_out 1, neg 1, ovf 0.
- 0x8000 − 0x0001 → 0x7FFF, ovf 1, b_out 0. 0x7FFF − 0xFFFF → 0x8000, ovf 1, b_out 1.
- 0x5555 − 0x5555: with b_in=0 → 0x0000, zero 1. With b_in=1 → 0xFFFF, b_out 1, zero 0.
- start pulsed at slice 1 with different operands → ignored; the original result completes unchanged. start held high during DONE → the second operation is accepted and its done follows 4 clocks later. Operand inputs changed mid-RUN have no effect.
- rst asserted while k=2 → all outputs 0 with no done pulse. A new request afterwards, 0x00FF − 0x000F, gives diff 0x00F0 with correct latency.
